// File: rtl/rv_pkg.sv
// Shared definitions for the 64-bit RISC-V datapath.
//   XLEN       : datapath width (only 64 is supported)
//   REG_ADDR_W : register index width
//   LD_*       : load funct3 encodings (size in [1:0], unsigned flag in [2])
package rv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational extraction and sign/zero extension of load data.
// Ports:
//   raw    in  XLEN  little-endian doubleword from data memory
//   offset in  3     byte offset within the doubleword (address[2:0])
//   funct3 in  3     load size/sign encoding (rv_pkg::LD_*)
//   ext    out XLEN  extended load value
// Misaligned offsets are aligned down to the access size; the reserved
// encoding 3'b111 returns the full doubleword like LD_D.
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);

    logic [5:0]      sh_b;
    logic [5:0]      sh_h;
    logic [5:0]      sh_w;
    logic [XLEN-1:0] raw_b;
    logic [XLEN-1:0] raw_h;
    logic [XLEN-1:0] raw_w;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     word_sel;

    // Shift amounts drop the offset bits below the access size (align down).
    assign sh_b = {offset, 3'b000};
    assign sh_h = {offset[2:1], 4'b0000};
    assign sh_w = {offset[2], 5'b00000};

    assign raw_b = raw >> sh_b;
    assign raw_h = raw >> sh_h;
    assign raw_w = raw >> sh_w;

    assign byte_sel = raw_b[7:0];
    assign half_sel = raw_h[15:0];
    assign word_sel = raw_w[31:0];

    always_comb begin
        ext = raw;
        case (funct3)
            LD_B:    ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_H:    ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_W:    ext = {{(XLEN-32){word_sel[31]}}, word_sel};
            LD_BU:   ext = {{(XLEN-8){1'b0}}, byte_sel};
            LD_HU:   ext = {{(XLEN-16){1'b0}}, half_sel};
            LD_WU:   ext = {{(XLEN-32){1'b0}}, word_sel};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction and
// write-back select.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            memory-stage slot holds a real instruction
//   stall, flush        hold contents / squash the incoming slot (flush wins)
//   reg_write_in        instruction writes rd
//   mem_to_reg_in       1 = load data, 0 = ALU result
//   funct3_in           load size/sign encoding
//   rd_in               destination register
//   alu_result_in       ALU result / effective address
//   read_data_in        raw doubleword from data memory
//   wb_valid            registered slot valid
//   wb_reg_write        register-file write enable (never set for x0)
//   wb_rd, wb_data      register-file write index and data / forwarding value
//   retire_count        (only with MEM_WB_RETIRE_CNT_EN) count of retired slots
// Optional feature macro: MEM_WB_RETIRE_CNT_EN adds the 64-bit retire counter.
module mem_wb_stage
    import rv_pkg::*;
#(
    parameter int XLEN       = rv_pkg::XLEN,
    parameter int REG_ADDR_W = rv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [2:0]            funct3_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       read_data_in,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
`ifdef MEM_WB_RETIRE_CNT_EN
    output logic [63:0]           retire_count,
`endif
    output logic [XLEN-1:0]       wb_data
);

    logic [XLEN-1:0]       load_val_p0;
    logic [XLEN-1:0]       wb_sel_p0;
    logic                  reg_write_p0;
    logic                  load_en_p0;

    logic                  vld_p1;
    logic                  reg_write_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic [XLEN-1:0]       data_p1;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .raw    (read_data_in),
        .offset (alu_result_in[2:0]),
        .funct3 (funct3_in),
        .ext    (load_val_p0)
    );

    assign wb_sel_p0    = mem_to_reg_in ? load_val_p0 : alu_result_in;
    // x0 is hardwired to zero, so a write to it is dropped here once.
    assign reg_write_p0 = in_valid & reg_write_in & (rd_in != '0);
    assign load_en_p0   = ~flush & ~stall;

    // ---- p0 -> p1: MEM/WB register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            rd_p1        <= '0;
            data_p1      <= '0;
        end else if (flush) begin
            // rd/data are don't-care in a bubble; holding them saves toggles.
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1       <= in_valid;
            reg_write_p1 <= reg_write_p0;
            rd_p1        <= rd_in;
            data_p1      <= wb_sel_p0;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_p1;

    // Wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_p1 <= '0;
        end else if (load_en_p0 && in_valid) begin
            retire_cnt_p1 <= retire_cnt_p1 + 64'd1;
        end
    end

    assign retire_count = retire_cnt_p1;
`endif

    assign wb_valid     = vld_p1;
    assign wb_reg_write = reg_write_p1;
    assign wb_rd        = rd_p1;
    assign wb_data      = data_p1;

endmodule
